// File: rtl/addsub_arbiter.sv
// Round-robin sequencer that shares one external add/sub unit between two requesters,
// returns each result on a tagged response handshake and keeps the last result for display.
module addsub_arbiter #(
   parameter int WIDTH    = 4,
   parameter int EXEC_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic             req_s0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic             req_s1,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_s,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_overflow,
   output logic [WIDTH-1:0] disp_value,
   output logic             disp_valid,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_LAT - 1);

   state_t        state;
   logic          rr;
   logic          gnt_id;
   logic [CW-1:0] cnt;

   assign fsm_state = state;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // req_ready is a combinational grant in IDLE only; rsp_valid holds until rsp_ready.
   always_comb begin
      req_ready = 2'b00;
      gnt_id    = (req_valid == 2'b11) ? rr : req_valid[1];
      if (!rst && state == IDLE && req_valid != 2'b00) begin
         req_ready = gnt_id ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr           <= 1'b0;
         cnt          <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_s        <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         disp_value   <= '0;
         disp_valid   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ready != 2'b00) begin
                  alu_a  <= gnt_id ? req_a1 : req_a0;
                  alu_b  <= gnt_id ? req_b1 : req_b0;
                  alu_s  <= gnt_id ? req_s1 : req_s0;
                  rsp_id <= gnt_id;
                  cnt    <= CNT_LOAD;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               // Operand regs stay put, so the shared unit sees stable inputs for EXEC_LAT cycles.
               if (cnt == '0) begin
                  rsp_result   <= alu_result;
                  rsp_overflow <= alu_overflow;
                  disp_value   <= alu_result;
                  disp_valid   <= 1'b1;
                  rsp_valid    <= 1'b1;
                  state        <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  rr        <= ~rsp_id;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
